aes_subbytes_pipe: RTL and testbench



---
 rtl/aes_subbytes_pipe.sv | 178 +++++++++++++++++
 tb/tb_aes_subbytes_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subbytes_pipe.sv
// Multi-lane AES SubBytes / InvSubBytes engine behind an elastic,
// fully stallable register pipeline. Each lane computes the S-box
// from GF(2^8) arithmetic instead of a ROM: multiplicative inverse
// plus the affine map. The inverse direction is the inverse affine
// map followed by the same field inverse.

module aes_sbox_lane #(
  parameter int ENABLE_INV = 1
) (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Field inverse as a^254; maps 0 to 0, which the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  // Forward affine map: b_i = x_i ^ x_i+4 ^ x_i+5 ^ x_i+6 ^ x_i+7 ^ 0x63_i.
  // A 3-bit index wraps modulo 8 on its own.
  function automatic logic [7:0] aff_fwd(input logic [7:0] x);
    logic [7:0] b;
    logic [2:0] j;
    b = 8'h63;
    for (int i = 0; i < 8; i++) begin
      j = 3'(i);
      b[j] = b[j] ^ x[j] ^ x[j + 3'd4] ^ x[j + 3'd5] ^ x[j + 3'd6] ^ x[j + 3'd7];
    end
    return b;
  endfunction

  // Inverse affine map: b_i = x_i+2 ^ x_i+5 ^ x_i+7 ^ 0x05_i.
  function automatic logic [7:0] aff_inv(input logic [7:0] x);
    logic [7:0] b;
    logic [2:0] j;
    b = 8'h05;
    for (int i = 0; i < 8; i++) begin
      j = 3'(i);
      b[j] = b[j] ^ x[j + 3'd2] ^ x[j + 3'd5] ^ x[j + 3'd7];
    end
    return b;
  endfunction

  logic [7:0] fwd;
  assign fwd = aff_fwd(gf_inv(din));

  if (ENABLE_INV != 0) begin : g_inv
    logic [7:0] bwd;
    assign bwd  = gf_inv(aff_inv(din));
    assign dout = inv ? bwd : fwd;
  end else begin : g_fwd
    logic unused_inv;
    assign unused_inv = inv;
    assign dout       = fwd;
  end

endmodule

module aes_subbytes_pipe #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 1,
  parameter int ENABLE_INV  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic [15:0]        beat_count
);

  localparam int S = PIPE_STAGES;

  logic [LANES-1:0][7:0]        sub_dat;
  logic [S-1:0]                 vld_q, vld_d;
  logic [S-1:0]                 inv_q, inv_d;
  logic [S-1:0][LANES-1:0][7:0] dat_q, dat_d;
  logic [S-1:0]                 load;
  logic [15:0]                  cnt_q, cnt_d;
  logic                         in_fire, out_fire;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane #(.ENABLE_INV(ENABLE_INV)) u_sbox (
      .din  (in_data[8*i +: 8]),
      .inv  (in_inv),
      .dout (sub_dat[i])
    );
  end

  // Stage k may load if any stage between it and the output has a hole, or
  // the output is draining; this unrolls the per-stage "empty or leaving" rule.
  always_comb begin : p_load
    logic acc;
    load = '0;
    acc  = out_ready;
    for (int k = S - 1; k >= 0; k--) begin
      acc     = acc | ~vld_q[k];
      load[k] = acc;
    end
  end

  // No beat is taken while reset is held.
  assign in_ready  = rst_n & load[0];
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld_q[S-1];
  assign out_fire  = out_valid & out_ready;
  assign out_data  = dat_q[S-1];
  assign out_inv   = inv_q[S-1];
  assign beat_count = cnt_q;

  // Advance the elastic chain; payloads only move when a valid beat arrives,
  // so a stalled output holds its data.
  always_comb begin
    vld_d = vld_q;
    inv_d = inv_q;
    dat_d = dat_q;
    cnt_d = cnt_q + {15'd0, out_fire};
    if (load[0]) begin
      vld_d[0] = in_fire;
      if (in_fire) begin
        dat_d[0] = sub_dat;
        inv_d[0] = (ENABLE_INV != 0) & in_inv;
      end
    end
    for (int k = 1; k < S; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_d[k] = dat_q[k-1];
          inv_d[k] = inv_q[k-1];
        end
      end
    end
  end

  // Pipeline and counter registers; reset discards every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      inv_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      inv_q <= inv_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Scoreboard bench for aes_subbytes_pipe. Expected words come from the
// published FIPS-197 S-box table; the inverse table is built by inverting it.
module tb_aes_subbytes_pipe;

  localparam int LANES = 4;
  localparam int PS    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
  logic [31:0] in_data, out_data;
  logic [15:0] beat_count;

  logic        b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
  logic [31:0] b_in_data, b_out_data;
  logic [15:0] b_beat_count;

  aes_subbytes_pipe #(.LANES(LANES), .PIPE_STAGES(PS), .ENABLE_INV(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv),
    .beat_count(beat_count)
  );

  aes_subbytes_pipe #(.LANES(LANES), .PIPE_STAGES(1), .ENABLE_INV(0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_inv(b_in_inv), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_inv(b_out_inv),
    .beat_count(b_beat_count)
  );

  logic [127:0] rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  typedef struct {
    logic [31:0] d;
    logic        inv;
    int          cyc;
  } exp_t;

  exp_t        sbq [$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          chk_lat = 1'b0;
  logic [15:0] exp_cnt = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
    logic [31:0] r;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = inv ? isbox[d[8*i +: 8]] : sbox[d[8*i +: 8]];
    return r;
  endfunction

  task automatic push(input logic [31:0] expd, input logic inv);
    exp_t e;
    e.d   = expd;
    e.inv = inv;
    e.cyc = cyc;
    sbq.push_back(e);
  endtask

  // Offer one beat until accepted; called at posedge+1, returns at posedge+1.
  task automatic send(input logic [31:0] d, input logic inv, input logic [31:0] expd);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clk);
      if (in_ready) begin push(expd, inv); done = 1'b1; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout got=no_accept want=accept t=%0t", $time);
    end
  endtask

  // inv_mode: 0 fwd, 1 alternate per beat, 2 random.
  task automatic run_stream(input int n, input bit rnd_ready, input int inv_mode, input bit rnd_valid);
    int sent;
    int guard;
    logic [31:0] d;
    sent = 0; guard = 0;
    while (sent < n && guard < n * 20 + 100) begin
      d = $urandom;
      in_valid  = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = d;
      in_inv    = (inv_mode == 2) ? 1'($urandom_range(0, 1)) : (inv_mode == 1) ? 1'(sent & 1) : 1'b0;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) begin push(model(d, in_inv), in_inv); sent++; end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (sent < n) begin
      total++; bad++;
      $display("FAIL stream_timeout got=%0d want=%0d", sent, n);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int g = 0; g < 200 && sbq.size() != 0; g++) @(posedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending", sbq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and check the immediate effect.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    sbq.delete();
    exp_cnt = 16'd0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: every output transfer must match the oldest expected beat.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out got=%h want=none", out_data);
      end else begin
        e = sbq.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_inv", out_inv, e.inv);
        if (chk_lat) chk("latency", 32'(cyc - e.cyc), PS);
      end
      chk("beat_count", beat_count, exp_cnt);
      exp_cnt = exp_cnt + 16'd1;
    end
  end

  initial begin
    int base;
    logic [31:0] w;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        sbox[16*r + c] = rows[r][127 - 8*c -: 8];
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_inv = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_inv", out_inv, 0);
    chk("reset_beat_count", beat_count, 0);
    chk("reset_in_ready", in_ready, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_b_in_ready", b_in_ready, 1);

    // Single-stage, forward-only build: directed examples.
    b_in_valid = 1'b1; b_in_data = 32'hFF530100; b_in_inv = 1'b0;
    @(negedge clk);
    chk("b_in_ready", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_data = 32'h00000000; b_in_inv = 1'b1;
    @(negedge clk);
    chk("b_valid1", b_out_valid, 1);
    chk("b_data1", b_out_data, 32'h16ED7C63);
    chk("b_inv1", b_out_inv, 0);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_count1", b_beat_count, 1);
    chk("b_data_noinv", b_out_data, 32'h63636363);
    chk("b_inv_tied", b_out_inv, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_idle", b_out_valid, 0);
    chk("b_count2", b_beat_count, 2);
    @(posedge clk); #1;

    // Round trip on the three-stage build.
    chk_lat = 1'b1;
    send(32'hFF530100, 1'b0, 32'h16ED7C63);
    send(32'h16ED7C63, 1'b1, 32'hFF530100);
    drain();

    // Sweep every byte value forward, then back through the inverse.
    for (int i = 0; i < 64; i++) begin
      w = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
      send(w, 1'b0, model(w, 1'b0));
    end
    for (int i = 0; i < 64; i++) begin
      w = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
      send(model(w, 1'b0), 1'b1, w);
    end
    drain();

    // Full rate with alternating mode: fixed latency on every beat means no bubbles.
    run_stream(16, 1'b0, 1, 1'b0);
    drain();

    // Backpressure: pipe holds exactly PS beats, then refuses.
    chk_lat = 1'b0;
    base = int'(exp_cnt);
    out_ready = 1'b0;
    send(32'h01020304, 1'b0, model(32'h01020304, 1'b0));
    send(32'h05060708, 1'b1, model(32'h05060708, 1'b1));
    @(negedge clk);
    chk("bp_not_full", in_ready, 1);
    @(posedge clk); #1;
    send(32'h090A0B0C, 1'b0, model(32'h090A0B0C, 1'b0));
    @(negedge clk);
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 3; i < 10; i++) begin
      w = $urandom;
      send(w, 1'(i & 1), model(w, 1'(i & 1)));
    end
    drain();
    chk("bp_beat_count", beat_count, 32'(16'(base + 10)));

    // Random valid/ready traffic.
    run_stream(400, 1'b1, 2, 1'b1);
    drain();

    // Reset with two beats in flight; nothing stale may appear afterwards.
    chk_lat = 1'b1;
    send(32'h11223344, 1'b0, model(32'h11223344, 1'b0));
    send(32'hA5A5A5A5, 1'b1, model(32'hA5A5A5A5, 1'b1));
    do_reset();
    chk("mid_rst_in_ready", in_ready, 1);
    send(32'h00000000, 1'b0, 32'h63636363);
    drain();

    // Counter wrap after 65536 transfers from reset.
    do_reset();
    run_stream(65536, 1'b0, 2, 1'b0);
    drain();
    @(negedge clk);
    chk("wrap_beat_count", beat_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
